// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_ctrl
// Purpose  : Byte-serial memory controller between the 8-bit unified RAM port
//            and two clients: the instruction fetcher (32-bit word reads) and
//            the load/store buffer (1/2/4-byte loads and stores). Arbitrates
//            the clients (load/store first), moves one byte per cycle on the
//            RAM bus, assembles/splits little-endian words and returns
//            one-cycle completion pulses.
// Ports    : clk, reset (async, active-low), rdy (global enable),
//            clear (aborts instruction reads), io_buffer_full,
//            mem_din/mem_dout/mem_a/mem_wr (RAM bus),
//            instr_if2mc_req/pc_if2mc/instr_mc2if_arrived/instr_mc2if (fetch),
//            ls_req/ls_wr/ls_addr/ls_size/ls_wdata/ls_mc2lsb_done/ls_rdata
//            (load/store buffer).
// Config   : MC_IO_STALL_EN - when defined, stores to I/O space
//            (ls_addr[17:16] == 2'b11) wait in IDLE while io_buffer_full.
// Revision : 1.0 - initial release
// ============================================================================
module mem_ctrl #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rdy,
    input  logic              clear,
    input  logic              io_buffer_full,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    input  logic              instr_if2mc_req,
    input  logic [ADDR_W-1:0] pc_if2mc,
    output logic              instr_mc2if_arrived,
    output logic [31:0]       instr_mc2if,
    input  logic              ls_req,
    input  logic              ls_wr,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [1:0]        ls_size,
    input  logic [31:0]       ls_wdata,
    output logic              ls_mc2lsb_done,
    output logic [31:0]       ls_rdata
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_WAIT  = 2'd3
    } state_t;

    state_t            r_state;
    logic [2:0]        r_cnt;    // READ: cycles spent in READ; WRITE: byte on bus
    logic [2:0]        r_len;    // transfer length in bytes (1, 2 or 4)
    logic              r_is_ls;  // 1 = load/store client, 0 = fetch
    logic [ADDR_W-1:0] r_base;
    logic [31:0]       r_wdata;  // remaining store bytes, next byte in [7:0]
    logic [31:0]       r_rbuf;   // read assembly buffer

    logic              w_ls_held;
    logic              w_ls_go;
    logic              w_if_go;
    logic [2:0]        w_len;
    logic [2:0]        w_next_off;
    logic [1:0]        w_cap_idx;
    logic              w_last_cap;
    logic [31:0]       w_rbuf_next;

`ifdef MC_IO_STALL_EN
    // I/O stores wait for room in the UART buffer; they stay pending in IDLE.
    assign w_ls_held = ls_wr && (ls_addr[17:16] == 2'b11) && io_buffer_full;
`else
    logic w_unused;
    assign w_unused  = io_buffer_full;
    assign w_ls_held = 1'b0;
`endif

    assign w_ls_go    = ls_req && !w_ls_held;
    // A held store does not block the fetcher; clear suppresses a new fetch.
    assign w_if_go    = instr_if2mc_req && !clear && !w_ls_go;
    assign w_next_off = r_cnt + 3'd1;
    // mem_din lags mem_a by one cycle, so byte k arrives when r_cnt == k+1.
    assign w_cap_idx  = 2'(r_cnt - 3'd1);
    assign w_last_cap = (r_cnt == r_len);

    // Size 3 is illegal; it is treated as a word access.
    always_comb begin
        w_len = 3'd4;
        case (ls_size)
            2'd0:    w_len = 3'd1;
            2'd1:    w_len = 3'd2;
            default: w_len = 3'd4;
        endcase
    end

    always_comb begin
        w_rbuf_next = r_rbuf;
        w_rbuf_next[{w_cap_idx, 3'b000} +: 8] = mem_din;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state             <= S_IDLE;
            r_cnt               <= 3'd0;
            r_len               <= 3'd0;
            r_is_ls             <= 1'b0;
            r_base              <= '0;
            r_wdata             <= 32'h0;
            r_rbuf              <= 32'h0;
            mem_a               <= '0;
            mem_wr              <= 1'b0;
            mem_dout            <= 8'h00;
            instr_mc2if_arrived <= 1'b0;
            instr_mc2if         <= 32'h0;
            ls_mc2lsb_done      <= 1'b0;
            ls_rdata            <= 32'h0;
        end else if (rdy) begin
            instr_mc2if_arrived <= 1'b0;
            ls_mc2lsb_done      <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_ls_go) begin
                        r_is_ls <= 1'b1;
                        r_base  <= ls_addr;
                        mem_a   <= ls_addr;
                        r_len   <= w_len;
                        r_cnt   <= 3'd0;
                        r_rbuf  <= 32'h0;
                        if (ls_wr) begin
                            mem_wr   <= 1'b1;
                            mem_dout <= ls_wdata[7:0];
                            r_wdata  <= {8'h00, ls_wdata[31:8]};
                            r_state  <= S_WRITE;
                        end else begin
                            r_state  <= S_READ;
                        end
                    end else if (w_if_go) begin
                        r_is_ls <= 1'b0;
                        r_base  <= pc_if2mc;
                        mem_a   <= pc_if2mc;
                        r_len   <= 3'd4;
                        r_cnt   <= 3'd0;
                        r_rbuf  <= 32'h0;
                        r_state <= S_READ;
                    end
                end
                S_READ: begin
                    // A flush wins even on the final capture edge.
                    if (!r_is_ls && clear) begin
                        r_state <= S_WAIT;
                    end else begin
                        if (r_cnt != 3'd0) begin
                            r_rbuf <= w_rbuf_next;
                        end
                        if (w_last_cap) begin
                            if (r_is_ls) begin
                                ls_rdata       <= w_rbuf_next;
                                ls_mc2lsb_done <= 1'b1;
                            end else begin
                                instr_mc2if         <= w_rbuf_next;
                                instr_mc2if_arrived <= 1'b1;
                            end
                            r_state <= S_WAIT;
                        end else begin
                            r_cnt <= w_next_off;
                            if (w_next_off < r_len) begin
                                mem_a <= r_base + ADDR_W'(w_next_off);
                            end
                        end
                    end
                end
                S_WRITE: begin
                    if (w_next_off < r_len) begin
                        r_cnt    <= w_next_off;
                        mem_a    <= r_base + ADDR_W'(w_next_off);
                        mem_dout <= r_wdata[7:0];
                        r_wdata  <= {8'h00, r_wdata[31:8]};
                    end else begin
                        mem_wr         <= 1'b0;
                        ls_mc2lsb_done <= 1'b1;
                        r_state        <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_ctrl
// Purpose  : Directed self-checking bench for mem_ctrl with a synchronous
//            byte RAM model (one-cycle read latency, halted while rdy is low).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        rdy;
    logic        clear;
    logic        io_buffer_full;
    logic [7:0]  mem_din = 8'h00;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        instr_if2mc_req;
    logic [31:0] pc_if2mc;
    logic        instr_mc2if_arrived;
    logic [31:0] instr_mc2if;
    logic        ls_req;
    logic        ls_wr;
    logic [31:0] ls_addr;
    logic [1:0]  ls_size;
    logic [31:0] ls_wdata;
    logic        ls_mc2lsb_done;
    logic [31:0] ls_rdata;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] ram [0:262143];

    mem_ctrl #(.ADDR_W(32)) dut (
        .clk                 (clk),
        .reset               (reset),
        .rdy                 (rdy),
        .clear               (clear),
        .io_buffer_full      (io_buffer_full),
        .mem_din             (mem_din),
        .mem_dout            (mem_dout),
        .mem_a               (mem_a),
        .mem_wr              (mem_wr),
        .instr_if2mc_req     (instr_if2mc_req),
        .pc_if2mc            (pc_if2mc),
        .instr_mc2if_arrived (instr_mc2if_arrived),
        .instr_mc2if         (instr_mc2if),
        .ls_req              (ls_req),
        .ls_wr               (ls_wr),
        .ls_addr             (ls_addr),
        .ls_size             (ls_size),
        .ls_wdata            (ls_wdata),
        .ls_mc2lsb_done      (ls_mc2lsb_done),
        .ls_rdata            (ls_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous RAM: read data for the address seen at an edge appears after it.
    always @(posedge clk) begin
        if (rdy) begin
            mem_din <= ram[mem_a[17:0]];
            if (mem_wr) ram[mem_a[17:0]] = mem_dout;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; rdy = 1'b1; clear = 1'b0; io_buffer_full = 1'b0;
        instr_if2mc_req = 1'b0; pc_if2mc = 32'h0;
        ls_req = 1'b0; ls_wr = 1'b0; ls_addr = 32'h0; ls_size = 2'd0; ls_wdata = 32'h0;
        tick(); tick();
        n_cmp++; if (mem_a !== 32'h0) begin n_err++; $display("FAIL reset_mem_a: got %h want 0", mem_a); end
        n_cmp++; if (mem_wr !== 1'b0) begin n_err++; $display("FAIL reset_mem_wr: got %b want 0", mem_wr); end
        n_cmp++; if (mem_dout !== 8'h0) begin n_err++; $display("FAIL reset_mem_dout: got %h want 0", mem_dout); end
        n_cmp++; if (instr_mc2if_arrived !== 1'b0) begin n_err++; $display("FAIL reset_arrived: got %b want 0", instr_mc2if_arrived); end
        n_cmp++; if (instr_mc2if !== 32'h0) begin n_err++; $display("FAIL reset_instr: got %h want 0", instr_mc2if); end
        n_cmp++; if (ls_mc2lsb_done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", ls_mc2lsb_done); end
        n_cmp++; if (ls_rdata !== 32'h0) begin n_err++; $display("FAIL reset_rdata: got %h want 0", ls_rdata); end
        @(negedge clk);
        reset = 1'b1;
        tick();
        n_cmp++; if (mem_wr !== 1'b0 || mem_a !== 32'h0) begin n_err++; $display("FAIL reset_idle: got wr=%b a=%h want wr=0 a=0", mem_wr, mem_a); end
    endtask

    task automatic test_fetch();
        logic [31:0] exp_a [6];
        exp_a = '{32'h100, 32'h101, 32'h102, 32'h103, 32'h103, 32'h103};
        instr_if2mc_req = 1'b1; pc_if2mc = 32'h100;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_cmp++; if (mem_a !== exp_a[i]) begin n_err++; $display("FAIL fetch_addr E%0d: got %h want %h", i, mem_a, exp_a[i]); end
            n_cmp++; if (mem_wr !== 1'b0) begin n_err++; $display("FAIL fetch_wr E%0d: got %b want 0", i, mem_wr); end
            n_cmp++; if (instr_mc2if_arrived !== 1'(i == 5)) begin n_err++; $display("FAIL fetch_arrived E%0d: got %b want %b", i, instr_mc2if_arrived, (i == 5)); end
        end
        n_cmp++; if (instr_mc2if !== 32'hEF000013) begin n_err++; $display("FAIL fetch_data: got %h want EF000013", instr_mc2if); end
        instr_if2mc_req = 1'b0;
        tick();
        n_cmp++; if (instr_mc2if_arrived !== 1'b0) begin n_err++; $display("FAIL fetch_pulse_width: got %b want 0", instr_mc2if_arrived); end
        n_cmp++; if (instr_mc2if !== 32'hEF000013) begin n_err++; $display("FAIL fetch_hold: got %h want EF000013", instr_mc2if); end
    endtask

    task automatic test_priority();
        logic [31:0] exp_a [4];
        exp_a = '{32'h200, 32'h201, 32'h201, 32'h201};
        ls_req = 1'b1; ls_wr = 1'b0; ls_size = 2'd1; ls_addr = 32'h200;
        instr_if2mc_req = 1'b1; pc_if2mc = 32'h100;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++; if (mem_a !== exp_a[i]) begin n_err++; $display("FAIL prio_addr E%0d: got %h want %h", i, mem_a, exp_a[i]); end
            n_cmp++; if (ls_mc2lsb_done !== 1'(i == 3)) begin n_err++; $display("FAIL prio_done E%0d: got %b want %b", i, ls_mc2lsb_done, (i == 3)); end
            n_cmp++; if (instr_mc2if_arrived !== 1'b0) begin n_err++; $display("FAIL prio_arrived E%0d: got %b want 0", i, instr_mc2if_arrived); end
        end
        n_cmp++; if (ls_rdata !== 32'h00001234) begin n_err++; $display("FAIL prio_rdata: got %h want 00001234", ls_rdata); end
        ls_req = 1'b0;
        tick();
        n_cmp++; if (mem_a !== 32'h201 || ls_mc2lsb_done !== 1'b0) begin n_err++; $display("FAIL prio_wait: got a=%h done=%b want a=201 done=0", mem_a, ls_mc2lsb_done); end
        tick();
        n_cmp++; if (mem_a !== 32'h100) begin n_err++; $display("FAIL prio_fetch_start: got %h want 100", mem_a); end
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++; if (instr_mc2if_arrived !== 1'(i == 4)) begin n_err++; $display("FAIL prio_fetch_arrived %0d: got %b want %b", i, instr_mc2if_arrived, (i == 4)); end
        end
        n_cmp++; if (instr_mc2if !== 32'hEF000013) begin n_err++; $display("FAIL prio_fetch_data: got %h want EF000013", instr_mc2if); end
        instr_if2mc_req = 1'b0;
        tick();
    endtask

    task automatic test_store();
        logic [31:0] exp_a [6];
        logic [7:0]  exp_d [4];
        int          wr_cycles;
        exp_a = '{32'h3FE, 32'h3FF, 32'h400, 32'h401, 32'h401, 32'h401};
        exp_d = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        wr_cycles = 0;
        ls_req = 1'b1; ls_wr = 1'b1; ls_size = 2'd2; ls_addr = 32'h3FE; ls_wdata = 32'hDEADBEEF;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (mem_wr === 1'b1) wr_cycles++;
            n_cmp++; if (mem_a !== exp_a[i]) begin n_err++; $display("FAIL store_addr E%0d: got %h want %h", i, mem_a, exp_a[i]); end
            n_cmp++; if (mem_wr !== 1'(i < 4)) begin n_err++; $display("FAIL store_wr E%0d: got %b want %b", i, mem_wr, (i < 4)); end
            if (i < 4) begin
                n_cmp++; if (mem_dout !== exp_d[i]) begin n_err++; $display("FAIL store_byte E%0d: got %h want %h", i, mem_dout, exp_d[i]); end
            end
            n_cmp++; if (ls_mc2lsb_done !== 1'(i == 4)) begin n_err++; $display("FAIL store_done E%0d: got %b want %b", i, ls_mc2lsb_done, (i == 4)); end
            if (i == 4) ls_req = 1'b0;
        end
        n_cmp++; if (wr_cycles != 4) begin n_err++; $display("FAIL store_wr_count: got %0d want 4", wr_cycles); end
        n_cmp++; if ({ram[18'h401], ram[18'h400], ram[18'h3FF], ram[18'h3FE]} !== 32'hDEADBEEF) begin
            n_err++; $display("FAIL store_ram: got %h%h%h%h want DEADBEEF", ram[18'h401], ram[18'h400], ram[18'h3FF], ram[18'h3FE]);
        end
    endtask

    task automatic test_clear();
        instr_if2mc_req = 1'b1; pc_if2mc = 32'h80; ls_wr = 1'b0;
        tick(); tick(); tick();
        clear = 1'b1;
        tick();
        clear = 1'b0; pc_if2mc = 32'h40;
        n_cmp++; if (instr_mc2if_arrived !== 1'b0) begin n_err++; $display("FAIL clear_abort: got %b want 0", instr_mc2if_arrived); end
        tick();
        n_cmp++; if (instr_mc2if_arrived !== 1'b0) begin n_err++; $display("FAIL clear_wait: got %b want 0", instr_mc2if_arrived); end
        tick();
        n_cmp++; if (mem_a !== 32'h40) begin n_err++; $display("FAIL clear_refetch_addr: got %h want 40", mem_a); end
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++; if (instr_mc2if_arrived !== 1'(i == 4)) begin n_err++; $display("FAIL clear_refetch_arrived %0d: got %b want %b", i, instr_mc2if_arrived, (i == 4)); end
        end
        n_cmp++; if (instr_mc2if !== 32'h12345678) begin n_err++; $display("FAIL clear_refetch_data: got %h want 12345678", instr_mc2if); end
        instr_if2mc_req = 1'b0;
        tick();
        // clear in IDLE blocks acceptance for that cycle only
        instr_if2mc_req = 1'b1; pc_if2mc = 32'h500; clear = 1'b1;
        tick();
        n_cmp++; if (mem_a !== 32'h43) begin n_err++; $display("FAIL clear_idle_block: got %h want 43", mem_a); end
        clear = 1'b0;
        tick();
        n_cmp++; if (mem_a !== 32'h500) begin n_err++; $display("FAIL clear_idle_accept: got %h want 500", mem_a); end
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++; if (instr_mc2if_arrived !== 1'(i == 4)) begin n_err++; $display("FAIL clear_idle_arrived %0d: got %b want %b", i, instr_mc2if_arrived, (i == 4)); end
        end
        n_cmp++; if (instr_mc2if !== 32'h0) begin n_err++; $display("FAIL clear_idle_data: got %h want 0", instr_mc2if); end
        instr_if2mc_req = 1'b0;
        tick();
    endtask

    task automatic test_stall();
        ls_req = 1'b1; ls_wr = 1'b0; ls_size = 2'd2; ls_addr = 32'h600;
        tick();
        n_cmp++; if (mem_a !== 32'h600) begin n_err++; $display("FAIL stall_a0: got %h want 600", mem_a); end
        tick();
        n_cmp++; if (mem_a !== 32'h601) begin n_err++; $display("FAIL stall_a1: got %h want 601", mem_a); end
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (mem_a !== 32'h601 || ls_mc2lsb_done !== 1'b0) begin n_err++; $display("FAIL stall_frozen %0d: got a=%h done=%b want a=601 done=0", i, mem_a, ls_mc2lsb_done); end
        end
        rdy = 1'b1;
        tick();
        n_cmp++; if (mem_a !== 32'h602) begin n_err++; $display("FAIL stall_a2: got %h want 602", mem_a); end
        tick();
        n_cmp++; if (mem_a !== 32'h603) begin n_err++; $display("FAIL stall_a3: got %h want 603", mem_a); end
        tick();
        n_cmp++; if (ls_mc2lsb_done !== 1'b0) begin n_err++; $display("FAIL stall_early_done: got %b want 0", ls_mc2lsb_done); end
        tick();
        n_cmp++; if (ls_mc2lsb_done !== 1'b1) begin n_err++; $display("FAIL stall_done: got %b want 1", ls_mc2lsb_done); end
        n_cmp++; if (ls_rdata !== 32'h44332211) begin n_err++; $display("FAIL stall_rdata: got %h want 44332211", ls_rdata); end
        rdy = 1'b0; ls_req = 1'b0;
        tick();
        n_cmp++; if (ls_mc2lsb_done !== 1'b1) begin n_err++; $display("FAIL stall_done_frozen: got %b want 1", ls_mc2lsb_done); end
        rdy = 1'b1;
        tick();
        n_cmp++; if (ls_mc2lsb_done !== 1'b0) begin n_err++; $display("FAIL stall_done_clear: got %b want 0", ls_mc2lsb_done); end
        tick();
    endtask

    task automatic test_io();
        ls_req = 1'b1; ls_wr = 1'b1; ls_size = 2'd0; ls_addr = 32'h30000; ls_wdata = 32'h000000A5;
        io_buffer_full = 1'b1;
`ifdef MC_IO_STALL_EN
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++; if (mem_wr !== 1'b0) begin n_err++; $display("FAIL io_held %0d: got wr=%b want 0", i, mem_wr); end
        end
        io_buffer_full = 1'b0;
`endif
        tick();
        n_cmp++; if (mem_wr !== 1'b1 || mem_a !== 32'h30000 || mem_dout !== 8'hA5) begin
            n_err++; $display("FAIL io_write: got wr=%b a=%h d=%h want wr=1 a=30000 d=A5", mem_wr, mem_a, mem_dout);
        end
        tick();
        n_cmp++; if (mem_wr !== 1'b0 || ls_mc2lsb_done !== 1'b1) begin n_err++; $display("FAIL io_done: got wr=%b done=%b want wr=0 done=1", mem_wr, ls_mc2lsb_done); end
        ls_req = 1'b0; io_buffer_full = 1'b0;
        tick();
        n_cmp++; if (ram[18'h30000] !== 8'hA5) begin n_err++; $display("FAIL io_ram: got %h want A5", ram[18'h30000]); end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_a [4];
        exp_a = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h0, 32'h1};
        instr_if2mc_req = 1'b1; pc_if2mc = 32'hFFFFFFFE;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (i < 4) begin
                n_cmp++; if (mem_a !== exp_a[i]) begin n_err++; $display("FAIL wrap_addr E%0d: got %h want %h", i, mem_a, exp_a[i]); end
            end
        end
        n_cmp++; if (instr_mc2if_arrived !== 1'b1 || instr_mc2if !== 32'hDDCCBBAA) begin
            n_err++; $display("FAIL wrap_data: got arrived=%b data=%h want 1 DDCCBBAA", instr_mc2if_arrived, instr_mc2if);
        end
        instr_if2mc_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        ls_req = 1'b1; ls_wr = 1'b1; ls_size = 2'd2; ls_addr = 32'h700; ls_wdata = 32'h11223344;
        tick(); tick();
        #2 reset = 1'b0;
        #1;
        n_cmp++; if (mem_wr !== 1'b0 || mem_a !== 32'h0 || mem_dout !== 8'h0) begin
            n_err++; $display("FAIL midreset_async: got wr=%b a=%h d=%h want 0 0 0", mem_wr, mem_a, mem_dout);
        end
        ls_req = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        tick(); tick();
        n_cmp++; if (mem_wr !== 1'b0 || ls_mc2lsb_done !== 1'b0) begin n_err++; $display("FAIL midreset_idle: got wr=%b done=%b want 0 0", mem_wr, ls_mc2lsb_done); end
        n_cmp++; if (ram[18'h700] !== 8'h44 || ram[18'h701] !== 8'h00) begin
            n_err++; $display("FAIL midreset_partial: got %h %h want 44 00", ram[18'h700], ram[18'h701]);
        end
    endtask

    initial begin
        for (int i = 0; i < 262144; i++) ram[i] = 8'h00;
        ram[18'h100] = 8'h13; ram[18'h101] = 8'h00; ram[18'h102] = 8'h00; ram[18'h103] = 8'hEF;
        ram[18'h200] = 8'h34; ram[18'h201] = 8'h12;
        ram[18'h040] = 8'h78; ram[18'h041] = 8'h56; ram[18'h042] = 8'h34; ram[18'h043] = 8'h12;
        ram[18'h600] = 8'h11; ram[18'h601] = 8'h22; ram[18'h602] = 8'h33; ram[18'h603] = 8'h44;
        ram[18'h3FFFE] = 8'hAA; ram[18'h3FFFF] = 8'hBB; ram[18'h0] = 8'hCC; ram[18'h1] = 8'hDD;

        test_reset();
        test_fetch();
        test_priority();
        test_store();
        test_clear();
        test_stall();
        test_io();
        test_wrap();
        test_reset_mid();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_ctrl.md
# mem_ctrl

Byte-serial memory controller between the 8-bit unified RAM port and the core's two memory clients: the instruction fetcher (word reads) and the load/store buffer (1/2/4-byte loads and stores). It arbitrates the clients, sequences one byte per cycle on the RAM bus, assembles or splits 32-bit little-endian words, and returns one-cycle completion pulses. The instruction fetcher consumes `instr_mc2if_arrived`/`instr_mc2if` directly.

## Interface
Parameters:
- `ADDR_W`, 32, address width on all ports.

Ports:
- `clk`  in  1  core clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-low; low clears all state immediately.
- `rdy`  in  1  global enable; low freezes every register.
- `clear`  in  1  misprediction flush; aborts instruction reads only.
- `io_buffer_full`  in  1  UART output buffer full.
- `mem_din`  in  8  RAM read byte.
- `mem_dout`  out  8  RAM write byte.
- `mem_a`  out  ADDR_W  RAM byte address.
- `mem_wr`  out  1  1 = write, 0 = read.
- `instr_if2mc_req`  in  1  fetch request, held until serviced.
- `pc_if2mc`  in  ADDR_W  fetch address.
- `instr_mc2if_arrived`  out  1  one-cycle fetch completion.
- `instr_mc2if`  out  32  fetched word.
- `ls_req`  in  1  load/store request, held until done.
- `ls_wr`  in  1  1 = store.
- `ls_addr`  in  ADDR_W  byte address.
- `ls_size`  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal.
- `ls_wdata`  in  32  store data; low bytes used.
- `ls_mc2lsb_done`  out  1  one-cycle load/store completion.
- `ls_rdata`  out  32  load data, zero-extended. The LSB performs sign extension.

## Operation
- States: IDLE, READ, WRITE, WAIT.
- Reset values:
  - `mem_a`=0, `mem_wr`=0, `mem_dout`=0, both done pulses 0, `instr_mc2if`=0, `ls_rdata`=0.
  - State IDLE, byte counter 0.
- IDLE:
  - `ls_req` has priority over `instr_if2mc_req`.
  - On accept, latch the address, length N (4 for fetch, 1/2/4 from `ls_size`), client and write data.
  - Drive byte 0, then go to READ or WRITE.
- READ:
  - Issue `mem_a` = base+k for k = 0..N-1.
  - `mem_din` carries the byte for the previous cycle's `mem_a`.
  - Capture byte k into bits [8k+7:8k].
  - After the final capture: register the result, pulse the client's done, go to WAIT.
- WRITE:
  - `mem_wr`=1; `mem_dout` = byte k of `ls_wdata`; `mem_a` = base+k.
  - After the last byte: `mem_wr`=0, pulse `ls_mc2lsb_done`, go to WAIT.
- WAIT:
  - Lasts one cycle. Requests are ignored so a client dropping `req` after done is not re-serviced. Then IDLE.
- `mem_wr` is 0 in every cycle except WRITE byte cycles.
- Outside READ/WRITE, `mem_a` holds its last value.
- Address arithmetic is modulo 2^ADDR_W; base+k wraps with no error.
- `clear`:
  - During an instruction READ: abort next edge, no `instr_mc2if_arrived`, go to WAIT.
  - In IDLE: suppresses acceptance of a fetch that cycle.
  - LS operations are never aborted.
- `clear` coinciding with the final fetch capture edge: abort wins, no pulse.
- A new request is accepted only in IDLE; while busy, the other client simply waits.

## Timing
- Request sampled in IDLE at edge E0: `mem_a`=base after E0.
- N-byte read: done pulse and data valid after edge E(N+1). Fetch: after E5.
- N-byte write: byte k on the bus after E(k); done after E(N).
- Done pulses are exactly one cycle wide. Data outputs hold until the next completion of the same client.
- Back-to-back throughput:
  - Fetch: one word per 7 cycles (accept, 4 address cycles, final capture, WAIT).
  - Store: N+2 cycles.
- `rdy` low: all registers hold, including counters and done pulses; resume exactly where frozen.
- `reset` asserted mid-operation: immediate return to reset values; the partial transfer is dropped.

## Configuration
- `MC_IO_STALL_EN`:
  - Defined: a store with `ls_addr[17:16]`==2'b11 (I/O space ≥ 0x30000) is held in IDLE while `io_buffer_full`=1, and is accepted on the first cycle it is 0.
  - Fetch requests may be accepted while the store is held.
- Undefined: `io_buffer_full` is ignored, and I/O stores proceed like any store.

## Test plan
- Reset, then fetch from `pc_if2mc`=0x100 with RAM bytes 13,00,00,EF at 0x100..0x103 -> `instr_mc2if_arrived` one cycle after E5, `instr_mc2if`=0xEF000013; `mem_wr`=0 throughout.
- Simultaneous `ls_req` (load, size 1, addr 0x200, RAM 0x34,0x12) and fetch request -> load served first, `ls_rdata`=0x00001234 after E3. Fetch then starts after the WAIT cycle.
- Store word 0xDEADBEEF at 0x3FE -> `mem_a` 0x3FE,0x3FF,0x400,0x401 with bytes EF,BE,AD,DE; `mem_wr`=1 for exactly 4 cycles; done after E4.
- Fetch in progress, `clear` pulsed after E2 -> no arrived pulse, WAIT then IDLE; a new fetch to 0x40 completes normally.
- Pull `rdy` low for 3 cycles mid-load -> outputs frozen; the result is identical to an unstalled run, shifted by 3 cycles.
- With `MC_IO_STALL_EN`, byte store to 0x30000 while `io_buffer_full`=1 for 5 cycles -> `mem_wr` stays 0 until full drops, then a single write of the byte. Without the macro, the write is issued immediately.
